clk_sync_rx_multi: RTL and testbench
====================================

// Module: clk_sync_rx_multi
// PURPOSE
//  Multi-channel receive-side synchroniser for single-bit signals arriving asynchronously into sys_clk.
//  Per channel: N-flop sync chain, optional glitch filter, mode-selected edge/toggle detect, saturating event counter.
//  Sits at domain boundaries (PHY status, toggle-encoded strobes from foreign-clock senders) in front of sys_clk logic.
// PARAMETERS
//  WIDTH        4   number of independent channels (>=1)
//  SYNC_STAGES  2   flops in sync chain (>=2)
//  FILTER_LEN   0   extra consecutive cycles a new synced value must persist before acceptance (0 = no filter)
//  CNT_W        8   per-channel event counter width (>=1)
//  MODE         {WIDTH{2'b00}}  packed 2 bits/channel, chan n at [2n+1:2n]: 00 toggle-decode (any edge), 01 rise, 10 fall, 11 disabled
// PORTS
//  sys_clk    in   1            single clock; all logic on posedge
//  sys_rst    in   1            synchronous, active-high reset
//  async_i    in   WIDTH        asynchronous inputs, no timing relation to sys_clk
//  cnt_clr    in   WIDTH        per-channel counter clear, sys_clk domain, level-sensitive
//  level_o    out  WIDTH        filtered synchronised level
//  pulse_o    out  WIDTH        one-cycle event strobe per MODE
//  evt_cnt_o  out  WIDTH*CNT_W  packed saturating event counts, chan n at [CNT_W*(n+1)-1:CNT_W*n]
// BEHAVIOUR
//  Reset: sync chain, filter counters, level_o, pulse_o, evt_cnt_o all 0 at first edge with sys_rst=1. Mid-operation
//   reset discards in-flight values. An input held 1 across reset release is detected as a 0->1 edge.
//  Sync: stage1 samples async_i[n]; s = last stage. Value stable before edge k appears on s after edge k+SYNC_STAGES-1.
//  Filter: counter fc increments each edge s!=level_o, clears when s==level_o. level_o flips at the edge where
//   s!=level_o and fc==FILTER_LEN; fc clears at that edge. FILTER_LEN=0: level_o <= s every edge.
//   Latency: stable change before edge k -> level_o updates at edge k+SYNC_STAGES+FILTER_LEN.
//   Glitch shorter than FILTER_LEN+1 cycles on s: no level_o change, no pulse. fc width = clog2(FILTER_LEN+1), min 1.
//  Edge detect (registered, same edge as level_o update): rise = 0->1, fall = 1->0, toggle = either.
//   pulse_o[n] high exactly one cycle per accepted change matching MODE; MODE 11 -> pulse_o[n] stays 0 (level_o still tracks).
//   Toggle mode decodes a sender toggling its line once per event: each accepted transition = one event.
//   Back-to-back accepted transitions (FILTER_LEN=0, input changing every cycle) give consecutive pulses, none merged.
//  Counter: increments at edge after pulse_o[n]=1; saturates at 2^CNT_W-1 (no wrap).
//   cnt_clr[n]=1 without event -> 0; cnt_clr[n] and increment same edge -> 1 (event not lost).
//   cnt_clr held high keeps counter at 0/1 per above rule. Channels fully independent; no cross-channel ordering.
//  Sync chain flops carry ASYNC_REG-style attribute; no combinational path from async_i to any output.
//  Inputs with events closer than SYNC_STAGES+FILTER_LEN+1 cycles are not guaranteed counted (sender's responsibility).
// STRUCTURE
//  Package clk_sync_pkg: MODE encodings MODE_TOGGLE=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_OFF=2'b11;
//   clog2 function for fc width.
//  Sub-module clk_sync_rx_chan (one channel: chain, filter, edge detect, counter; params SYNC_STAGES, FILTER_LEN,
//   CNT_W, CH_MODE); top is a generate loop over WIDTH plus bus packing.
// TESTING
//  1 WIDTH=4, SYNC_STAGES=2, FILTER_LEN=0, MODE all rise; async_i[0] 0->1 before edge 10 -> level_o[0]=1 and
//    pulse_o[0]=1 after edge 12 only, evt_cnt ch0=1 after edge 13; other channels 0.
//  2 FILTER_LEN=3: 2-cycle high glitch on ch1 -> no level/pulse; 6-cycle high -> level_o[1] rises at edge k+5, one pulse.
//  3 MODE ch2=toggle: toggle async_i[2] 5 times, 10 cycles apart -> 5 pulses, count=5; MODE ch3=off -> 0 pulses, level tracks.
//  4 CNT_W=3, 9 rising events ch0 -> count sticks at 7; cnt_clr same cycle as increment -> count=1; cnt_clr alone -> 0.
//  5 Fall mode, async_i=1 through reset: after release, one rise accepted (no pulse in fall mode), then 1->0 -> one pulse.
//  6 Assert sys_rst mid-filter/mid-chain (ch1 pending) -> all outputs 0 next edge; pending change not reported until re-synced.

Source files
------------

// File: rtl/clk_sync_pkg.sv
// clk_sync_pkg: mode encodings and width helper shared by the multi-channel receive synchroniser
package clk_sync_pkg;
    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_RISE   = 2'b01;
    localparam logic [1:0] MODE_FALL   = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/clk_sync_rx_chan.sv
// clk_sync_rx_chan: one channel of sync chain, glitch filter, edge detect and saturating event counter
module clk_sync_rx_chan
    import clk_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 0,
    parameter int CNT_W = 8,
    parameter logic [1:0] CH_MODE = MODE_TOGGLE
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic async_i,
    input  logic clr_i,
    output logic level_o,
    output logic pulse_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int FW = clog2(FILTER_LEN + 1) > 0 ? clog2(FILTER_LEN + 1) : 1;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0] fc_q, fc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic level_q, level_d, pulse_q, pulse_d, s, accept;
    always_comb begin
        s = sync_q[SYNC_STAGES-1];
        accept = (s != level_q) && (fc_q == FW'(FILTER_LEN));
        fc_d = (s == level_q || accept) ? '0 : fc_q + 1'b1;
        level_d = accept ? s : level_q;
        pulse_d = accept && (CH_MODE == MODE_TOGGLE || (CH_MODE == MODE_RISE && s) || (CH_MODE == MODE_FALL && !s));
        // a clear coinciding with an event keeps that event
        cnt_d = clr_i ? CNT_W'(pulse_q) : (pulse_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '0;
            fc_q <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            fc_q <= fc_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q <= cnt_d;
        end
    end
    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/clk_sync_rx_multi.sv
// clk_sync_rx_multi: WIDTH independent receive synchronisers with per-channel mode and packed counters
module clk_sync_rx_multi
    import clk_sync_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 0,
    parameter int CNT_W = 8,
    parameter logic [2*WIDTH-1:0] MODE = {WIDTH{MODE_TOGGLE}}
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic [WIDTH-1:0] async_i,
    input  logic [WIDTH-1:0] cnt_clr,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] pulse_o,
    output logic [WIDTH*CNT_W-1:0] evt_cnt_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        clk_sync_rx_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN(FILTER_LEN),
            .CNT_W(CNT_W),
            .CH_MODE(MODE[2*i +: 2])
        ) u_chan (
            .sys_clk(sys_clk),
            .sys_rst(sys_rst),
            .async_i(async_i[i]),
            .clr_i(cnt_clr[i]),
            .level_o(level_o[i]),
            .pulse_o(pulse_o[i]),
            .cnt_o(evt_cnt_o[CNT_W*i +: CNT_W])
        );
    end
endmodule

// File: tb/tb_clk_sync_rx_multi.sv
// tb_clk_sync_rx_multi: directed checks on an unfiltered mixed-mode instance and a filtered rise-mode instance
module tb_clk_sync_rx_multi;
    logic sys_clk = 1'b0;
    logic sys_rst;
    logic [3:0] async_a, clr_a, level_a, pulse_a;
    logic [3:0] async_b, clr_b, level_b, pulse_b;
    logic [11:0] cnt_a;
    logic [31:0] cnt_b;
    logic seen;
    int n_pass = 0;
    int n_total = 0;

    always #5 sys_clk = ~sys_clk;

    // ch0 rise, ch1 fall, ch2 toggle, ch3 off
    clk_sync_rx_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(0), .CNT_W(3), .MODE(8'b11_00_10_01)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .async_i(async_a), .cnt_clr(clr_a),
        .level_o(level_a), .pulse_o(pulse_a), .evt_cnt_o(cnt_a)
    );
    clk_sync_rx_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_LEN(3), .CNT_W(8), .MODE(8'b01_01_01_01)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .async_i(async_b), .cnt_clr(clr_b),
        .level_o(level_b), .pulse_o(pulse_b), .evt_cnt_o(cnt_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        sys_rst = 1'b1;
        async_a = 4'b0010;
        async_b = 4'b0000;
        clr_a = 4'b0000;
        clr_b = 4'b0000;
        cyc(3);
        chk("rst_level_a", level_a, 0);
        chk("rst_pulse_a", pulse_a, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_level_b", level_b, 0);
        chk("rst_cnt_b", cnt_b, 0);
        // input held high across reset release reads as a rise
        sys_rst = 1'b0;
        cyc(2);
        chk("rel_level_early", level_a, 4'b0000);
        cyc(1);
        chk("rel_level_rise", level_a, 4'b0010);
        chk("rel_no_pulse_fall_mode", pulse_a, 4'b0000);
        async_a[1] = 1'b0;
        cyc(2);
        chk("fall_level_early", level_a, 4'b0010);
        cyc(1);
        chk("fall_level", level_a, 4'b0000);
        chk("fall_pulse", pulse_a, 4'b0010);
        cyc(1);
        chk("fall_pulse_one_cycle", pulse_a, 4'b0000);
        chk("fall_cnt", cnt_a[5:3], 1);
        async_a[0] = 1'b1;
        cyc(2);
        chk("rise_level_early", level_a, 4'b0000);
        chk("rise_pulse_early", pulse_a, 4'b0000);
        cyc(1);
        chk("rise_level", level_a, 4'b0001);
        chk("rise_pulse", pulse_a, 4'b0001);
        cyc(1);
        chk("rise_pulse_one_cycle", pulse_a, 4'b0000);
        chk("rise_cnt", cnt_a[2:0], 1);
        chk("rise_other_cnts", cnt_a[11:6], 0);
        // eight more rises: nine total saturates a 3-bit counter at 7
        for (int i = 0; i < 8; i++) begin
            async_a[0] = 1'b0;
            cyc(5);
            async_a[0] = 1'b1;
            cyc(5);
        end
        chk("sat_cnt", cnt_a[2:0], 7);
        async_a[0] = 1'b0;
        cyc(5);
        async_a[0] = 1'b1;
        cyc(3);
        chk("clr_inc_pulse", pulse_a[0], 1);
        clr_a[0] = 1'b1;
        cyc(1);
        clr_a[0] = 1'b0;
        chk("clr_with_inc", cnt_a[2:0], 1);
        clr_a[0] = 1'b1;
        cyc(1);
        clr_a[0] = 1'b0;
        chk("clr_alone", cnt_a[2:0], 0);
        cyc(1);
        chk("clr_stays", cnt_a[2:0], 0);
        // toggle ch2 every cycle: four consecutive pulses
        for (int i = 0; i < 7; i++) begin
            if (i < 4) async_a[2] = ~async_a[2];
            cyc(1);
            chk("b2b_pulse", pulse_a[2], (i >= 2 && i <= 5));
        end
        chk("b2b_cnt", cnt_a[8:6], 4);
        clr_a[2] = 1'b1;
        cyc(1);
        clr_a[2] = 1'b0;
        chk("b2b_clr", cnt_a[8:6], 0);
        for (int i = 0; i < 5; i++) begin
            async_a[2] = ~async_a[2];
            async_a[3] = ~async_a[3];
            cyc(3);
            chk("tog_pulse", pulse_a[3:2], 2'b01);
            chk("off_level", level_a[3], async_a[3]);
            cyc(7);
        end
        chk("tog_cnt", cnt_a[8:6], 5);
        chk("off_cnt", cnt_a[11:9], 0);
        // filtered instance: a 2-cycle glitch must vanish
        seen = 1'b0;
        async_b[1] = 1'b1;
        cyc(2);
        async_b[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            seen = seen | level_b[1] | pulse_b[1];
        end
        chk("glitch_ignored", seen, 0);
        async_b[1] = 1'b1;
        cyc(5);
        chk("filt_level_early", level_b, 4'b0000);
        cyc(1);
        chk("filt_level", level_b, 4'b0010);
        chk("filt_pulse", pulse_b, 4'b0010);
        async_b[1] = 1'b0;
        cyc(1);
        chk("filt_pulse_one_cycle", pulse_b, 4'b0000);
        chk("filt_cnt", cnt_b[15:8], 1);
        cyc(8);
        chk("filt_level_fell", level_b[1], 0);
        chk("filt_cnt_rise_only", cnt_b[15:8], 1);
        // reset while a change is in flight
        async_b[1] = 1'b1;
        cyc(4);
        sys_rst = 1'b1;
        cyc(1);
        chk("midrst_level_b", level_b, 0);
        chk("midrst_pulse_b", pulse_b, 0);
        chk("midrst_cnt_b", cnt_b, 0);
        chk("midrst_level_a", level_a, 0);
        chk("midrst_cnt_a", cnt_a, 0);
        sys_rst = 1'b0;
        cyc(5);
        chk("resync_early", level_b[1], 0);
        cyc(1);
        chk("resync_level", level_b[1], 1);
        chk("resync_pulse", pulse_b, 4'b0010);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
